// File: rtl/input_capture_fifo_v2.sv
// Input-capture unit: timestamps edges on ins, checks inter-edge periodicity, queues result words.
// Define IC_FREQ_DIV_EN to add the sequential FREQ_NUM / period divider that fills the F field.
module input_capture_fifo_v2 #(
    parameter int unsigned TW        = 16,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned TICK_NS   = 10,
    parameter int unsigned FREQ_NUM  = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ins,
    input  logic [1:0]    ICTMR,
    input  logic          tmr_sel,
    input  logic [TW-1:0] t_val_bi_0,
    input  logic [TW-1:0] t_val_bi_1,
    input  logic          rd_i,
    output logic          ICBNE,
    output logic          ICOV,
    output logic [31:0]   ICBUF
);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned AW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned PNW = TW + 1 + 32;

    logic          ins_s1, ins_s2, ins_prev;
    logic [1:0]    mode_q;
    logic          mode_chg, rise, fall, cap;
    logic [TW-1:0] hist [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          pend;

    assign mode_chg = (ICTMR != mode_q);
    assign rise     = ins_s2 & ~ins_prev;
    assign fall     = ~ins_s2 & ins_prev;
    assign cap      = ((rise & ICTMR[0]) | (fall & ICTMR[1])) & ~mode_chg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_s1   <= 1'b0;
            ins_s2   <= 1'b0;
            ins_prev <= 1'b0;
            mode_q   <= '0;
            ptr      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
        end else begin
            ins_s1   <= ins;
            ins_s2   <= ins_s1;
            ins_prev <= ins_s2;
            mode_q   <= ICTMR;
            pend     <= 1'b0;
            if (mode_chg) begin
                ptr <= '0;
                cnt <= '0;
            end else if (cap) begin
                ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                if (cnt != CW'(DEPTH))
                    cnt <= cnt + 1'b1;
                // this capture fills (or keeps full) the history, so it yields a result
                pend <= (cnt >= CW'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap)
            hist[ptr] <= tmr_sel ? t_val_bi_1 : t_val_bi_0;
    end

    logic [TW-1:0] dlt [DEPTH-1];
    logic          stable;
    logic [TW:0]   per;

    always_comb begin
        int unsigned a, b;
        a = 0;
        b = 0;
        for (int unsigned j = 0; j < DEPTH - 1; j++) begin
            a      = (32'(ptr) + 2 * DEPTH - 1 - j) % DEPTH;
            b      = (32'(ptr) + 2 * DEPTH - 2 - j) % DEPTH;
            dlt[j] = hist[PW'(a)] - hist[PW'(b)];
        end
    end

    always_comb begin
        stable = 1'b1;
        per    = '0;
        if (mode_q == 2'b11) begin
            for (int unsigned j = 0; j + 2 < DEPTH - 1; j++)
                if (dlt[j] != dlt[j + 2]) stable = 1'b0;
            per = {1'b0, dlt[0]} + {1'b0, dlt[1]};
        end else begin
            for (int unsigned j = 1; j < DEPTH - 1; j++)
                if (dlt[j] != dlt[0]) stable = 1'b0;
            per = {1'b0, dlt[0]};
        end
    end

    logic [PNW-1:0] pns_full;
    logic [14:0]    pns_sat;

    assign pns_full = PNW'(per) * PNW'(TICK_NS);
    assign pns_sat  = (pns_full > PNW'(15'h7FFF)) ? 15'h7FFF : pns_full[14:0];

    logic        push;
    logic [31:0] push_word;
    logic        div_drop;

`ifdef IC_FREQ_DIV_EN
    typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

    div_state_t  div_st;
    logic [4:0]  div_step;
    logic [31:0] div_dvd, div_dsr, div_quo, div_rem;
    logic        div_stable;
    logic [14:0] div_pns;
    logic [32:0] rem_sh, rem_sub;
    logic        q_bit;
    logic [31:0] quo_nxt;
    logic [14:0] f_sat;

    assign rem_sh  = {div_rem, div_dvd[31]};
    assign rem_sub = rem_sh - {1'b0, div_dsr};
    assign q_bit   = ~rem_sub[32];
    assign quo_nxt = {div_quo[30:0], q_bit};
    assign f_sat   = (div_dsr == '0 || quo_nxt > 32'h7FFF) ? 15'h7FFF : quo_nxt[14:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            div_st     <= DIV_IDLE;
            div_step   <= '0;
            div_dvd    <= '0;
            div_dsr    <= '0;
            div_quo    <= '0;
            div_rem    <= '0;
            div_stable <= 1'b0;
            div_pns    <= '0;
        end else if (mode_chg) begin
            div_st <= DIV_IDLE;
        end else begin
            case (div_st)
                DIV_IDLE: if (pend) begin
                    div_st     <= DIV_RUN;
                    div_step   <= '0;
                    div_dvd    <= FREQ_NUM;
                    div_dsr    <= pns_full[31:0];
                    div_quo    <= '0;
                    div_rem    <= '0;
                    div_stable <= stable;
                    div_pns    <= pns_sat;
                end
                DIV_RUN: begin
                    div_rem  <= q_bit ? rem_sub[31:0] : rem_sh[31:0];
                    div_quo  <= quo_nxt;
                    div_dvd  <= {div_dvd[30:0], 1'b0};
                    div_step <= div_step + 1'b1;
                    if (div_step == 5'd31)
                        div_st <= DIV_IDLE;
                end
                default: div_st <= DIV_IDLE;
            endcase
        end
    end

    // final quotient bit is resolved combinationally so the push lands on the 32nd step
    assign push      = (div_st == DIV_RUN) && (div_step == 5'd31) && !mode_chg;
    assign push_word = div_stable ? {2'b11, f_sat, div_pns} : {2'b10, 30'd0};
    assign div_drop  = pend && !mode_chg && (div_st == DIV_RUN);
`else
    assign push      = pend & ~mode_chg;
    assign push_word = stable ? {2'b11, 15'd0, pns_sat} : {2'b10, 30'd0};
    assign div_drop  = 1'b0;
`endif

    logic [31:0] fifo [OUT_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en, drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rd_i & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = (push & full & ~pop) | div_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ICOV   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                ICOV <= 1'b1;
            else if (pop)
                ICOV <= 1'b0;
        end
    end

    // on push+pop while full the tail slot is the one being vacated by the head
    always_ff @(posedge clk) begin
        if (wr_en)
            fifo[wr_ptr[AW-1:0]] <= push_word;
    end

    assign ICBNE = ~empty;
    assign ICBUF = empty ? '0 : fifo[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_input_capture_fifo_v2.sv
// Directed bench for input_capture_fifo_v2 (default build, divider macro undefined).
module tb_input_capture_fifo_v2;
    logic        clk = 1'b0;
    logic        rst;
    logic        ins;
    logic [1:0]  ICTMR;
    logic        tmr_sel;
    logic [15:0] tmr0, tmr1;
    logic        rd_i;
    logic        ICBNE, ICOV;
    logic [31:0] ICBUF;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] W_C8   = 32'hC00000C8;
    localparam logic [31:0] W_3E8  = 32'hC00003E8;
    localparam logic [31:0] W_258  = 32'hC0000258;
    localparam logic [31:0] W_SAT  = 32'hC0007FFF;
    localparam logic [31:0] W_UNST = 32'h80000000;

    input_capture_fifo_v2 #(
        .TW(16), .DEPTH(5), .OUT_DEPTH(4), .TICK_NS(10), .FREQ_NUM(1000000)
    ) dut (
        .clk(clk), .rst(rst), .ins(ins), .ICTMR(ICTMR), .tmr_sel(tmr_sel),
        .t_val_bi_0(tmr0), .t_val_bi_1(tmr1), .rd_i(rd_i),
        .ICBNE(ICBNE), .ICOV(ICOV), .ICBUF(ICBUF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // timer 0 advances 1 tick per cycle, timer 1 advances 3
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tmr0 = tmr0 + 16'd1;
            tmr1 = tmr1 + 16'd3;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ins = 1'b0; rd_i = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic period(input string tag, input int h, input int l,
                          input logic exp_bne, input logic [31:0] exp_buf, input logic do_pop);
        ins = 1'b1;
        step(h);
        ins = 1'b0;
        step(l - 1);
        check({tag, "_bne"}, 32'(ICBNE), 32'(exp_bne));
        check({tag, "_buf"}, ICBUF, exp_buf);
        if (do_pop) rd_i = 1'b1;
        step(1);
        rd_i = 1'b0;
    endtask

    task automatic drain(input string tag, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (ICBNE) begin
                rd_i = 1'b1;
                step(1);
                rd_i = 1'b0;
                n++;
            end
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ins = 1'b0; rd_i = 1'b0; ICTMR = 2'b01; tmr_sel = 1'b0;
        tmr0 = 16'd0; tmr1 = 16'd0;

        // rising edges every 20 cycles, including exact result latency
        do_reset();
        check("rst_bne", 32'(ICBNE), 32'd0);
        check("rst_ov",  32'(ICOV),  32'd0);
        check("rst_buf", ICBUF,      32'd0);
        for (int i = 0; i < 4; i++) period("r_fill", 10, 10, 1'b0, 32'd0, 1'b0);
        ins = 1'b1;
        step(3);
        check("r_lat_e1", 32'(ICBNE), 32'd0);
        step(1);
        check("r_lat_e2_bne", 32'(ICBNE), 32'd1);
        check("r_lat_e2_buf", ICBUF, W_C8);
        step(6);
        ins = 1'b0;
        step(9);
        rd_i = 1'b1;
        step(1);
        rd_i = 1'b0;
        check("r_pop_empty", 32'(ICBNE), 32'd0);
        period("r_e6", 10, 10, 1'b1, W_C8, 1'b1);

        // timer wrap straddled by the history
        do_reset();
        tmr0 = 16'hFFC0;
        for (int i = 0; i < 8; i++)
            period("wrap", 10, 10, i >= 4, (i >= 4) ? W_C8 : 32'd0, i >= 4);

        // both edges, high 30 / low 70
        ICTMR = 2'b11;
        do_reset();
        for (int i = 0; i < 2; i++) period("b_fill", 30, 70, 1'b0, 32'd0, 1'b0);
        ins = 1'b1;
        step(10);
        check("b_rise_bne", 32'(ICBNE), 32'd1);
        check("b_rise_buf", ICBUF, W_3E8);
        rd_i = 1'b1;
        step(1);
        rd_i = 1'b0;
        step(19);
        ins = 1'b0;
        step(10);
        check("b_fall_bne", 32'(ICBNE), 32'd1);
        check("b_fall_buf", ICBUF, W_3E8);
        rd_i = 1'b1;
        step(1);
        rd_i = 1'b0;
        check("b_single", 32'(ICBNE), 32'd0);
        step(59);

        // jitter on timer 1: spacing 20,20,21,20 then steady 20
        ICTMR = 2'b01;
        tmr_sel = 1'b1;
        do_reset();
        period("j1", 10, 10, 1'b0, 32'd0, 1'b0);
        period("j2", 10, 10, 1'b0, 32'd0, 1'b0);
        period("j3", 10, 11, 1'b0, 32'd0, 1'b0);
        period("j4", 10, 10, 1'b0, 32'd0, 1'b0);
        period("j5", 10, 10, 1'b1, W_UNST, 1'b1);
        period("j6", 10, 10, 1'b1, W_UNST, 1'b1);
        period("j7", 10, 10, 1'b1, W_UNST, 1'b1);
        period("j8", 10, 10, 1'b1, W_258, 1'b1);

        // long period saturates Pns at 0x7FFF
        do_reset();
        for (int i = 0; i < 6; i++)
            period("sat", 600, 600, i >= 4, (i >= 4) ? W_SAT : 32'd0, i >= 4);

        // overflow, pop clearing ICOV, push+pop while full
        tmr_sel = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) period("o_fill", 10, 10, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) period("o_q", 10, 10, 1'b1, W_C8, 1'b0);
        check("o_full_ov", 32'(ICOV), 32'd0);
        period("o_e9", 10, 10, 1'b1, W_C8, 1'b0);
        check("o_drop_ov", 32'(ICOV), 32'd1);
        period("o_e10", 10, 10, 1'b1, W_C8, 1'b1);
        check("o_pop_ov", 32'(ICOV), 32'd0);
        period("o_e11", 10, 10, 1'b1, W_C8, 1'b0);
        check("o_refull_ov", 32'(ICOV), 32'd0);
        ins = 1'b1;
        step(3);
        rd_i = 1'b1;
        step(1);
        rd_i = 1'b0;
        step(6);
        ins = 1'b0;
        step(10);
        check("o_pushpop_ov", 32'(ICOV), 32'd0);
        drain("o_count", 4);

        // reset with FIFO full, ICOV set and a result in flight
        do_reset();
        for (int i = 0; i < 4; i++) period("x_fill", 10, 10, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) period("x_q", 10, 10, 1'b1, W_C8, 1'b0);
        check("x_pre_ov", 32'(ICOV), 32'd1);
        ins = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("x_rst_bne", 32'(ICBNE), 32'd0);
        check("x_rst_ov",  32'(ICOV),  32'd0);
        check("x_rst_buf", ICBUF,      32'd0);
        step(8);
        check("x_abort_bne", 32'(ICBNE), 32'd0);
        ins = 1'b0;
        step(10);

        // mode change 01 -> 10 keeps queued word, restarts history
        do_reset();
        for (int i = 0; i < 4; i++) period("m_fill", 10, 10, 1'b0, 32'd0, 1'b0);
        period("m_e5", 10, 10, 1'b1, W_C8, 1'b0);
        ICTMR = 2'b10;
        for (int i = 0; i < 5; i++) period("m_fall", 10, 10, 1'b1, W_C8, 1'b0);
        drain("m_count", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_capture_fifo_v2.md
Name: input_capture_fifo_v2

Overview:
- Parametrised input-capture unit that timestamps edges on `ins` against one of two free-running timers.
- Keeps a circular history of DEPTH timestamps and checks the inter-edge deltas for periodicity.
- Pushes one {valid, stable, frequency, period} result word per qualifying edge into an output FIFO that the host pops with `rd_i`.
- Sits between the timer block and the bus interface; adds configurable depth/width, a both-edge mode, timer select, overflow signalling and timer wrap handling.

Parameters:
- TW, 16: timer width in bits.
- DEPTH, 5: timestamp history length, minimum 3.
- OUT_DEPTH, 4: output FIFO entries, power of 2.
- TICK_NS, 10: nanoseconds per timer tick.
- FREQ_NUM, 1000000: dividend for the frequency field (gives kHz when period is in ns).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ins  in  1  asynchronous capture input
- ICTMR  in  2  mode: 00 off, 01 rising, 10 falling, 11 both edges
- tmr_sel  in  1  0 selects t_val_bi_0, 1 selects t_val_bi_1
- t_val_bi_0  in  TW  timer 0 value
- t_val_bi_1  in  TW  timer 1 value
- rd_i  in  1  pop request
- ICBNE  out  1  output FIFO not empty
- ICOV  out  1  sticky overflow flag
- ICBUF  out  32  FIFO head word

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: ICBNE=0, ICOV=0, ICBUF=0. History count=0, history pointer=0, FIFO empty, divider idle. A reset mid-operation aborts any pending result or division.
- Input path: `ins` passes through a 2-FF synchroniser plus a previous-value register.
- Edge detection: an edge is detected in cycle E when the synchronised value differs from the previous value and the edge type matches ICTMR. ICTMR=00 detects nothing.
- Capture: in cycle E, the selected timer value is written at the history pointer. The pointer advances modulo DEPTH and the count saturates at DEPTH.
- Mode change: any change of ICTMR (compared with its value in the previous cycle) clears the history count and pointer and discards an uncommitted result. The output FIFO is untouched.
- Deltas: d_k = ts_k - ts_(k-1) modulo 2^TW, so timer wrap-around is transparent.
- Result generation: none while count < DEPTH. Once count == DEPTH, every capture generates one result from the DEPTH-1 newest deltas.
  - Modes 01/10: stable = all deltas equal; P = newest delta.
  - Mode 11: stable = d_k == d_(k-2) for every available pair; P = sum of the two newest deltas.
- Result word:
  - Stable: ICBUF word = {1, 1, F[14:0], Pns[14:0]}, where Pns = P*TICK_NS saturated to 0x7FFF and F = 0 (see the Optional Feature).
  - Unstable: ICBUF word = {1, 0, 30'd0}.
- Latency (macro off): the result is pushed at the end of cycle E+1. ICBNE and ICBUF reflect it from cycle E+2.
- Output FIFO: first-word fall-through. ICBUF = head word, or 0 when empty. ICBNE = not empty.
- Pop: `rd_i` in a cycle with ICBNE=1 pops at the clock edge. `rd_i` while empty is ignored.
- Full FIFO:
  - Push and pop in the same cycle while full: both succeed, ICOV is unchanged.
  - Push while full without a pop: the new word is dropped and ICOV is set.
  - ICOV clears on the next successful pop. If a drop and a pop coincide, set wins.
- Simultaneous edges: captures closer together than the result latency are each processed in order. Nothing is lost at the detection stage; edge spacing is at least 1 cycle after synchronisation.

Optional Feature:
- Macro: IC_FREQ_DIV_EN.
- Defined:
  - Every result, stable or unstable, goes through a 32-cycle sequential restoring divider, 1 quotient bit per cycle, computing FREQ_NUM / Pns_unsat.
  - The quotient is saturated to 0x7FFF and placed in F. If Pns_unsat == 0, F = 0x7FFF. Unstable words keep F = 0 but still take the divider slot, so order is preserved.
  - The divider starts in E+1, the push happens at the end of E+33, and the word is visible from E+34.
  - A new result arriving while the divider is busy is dropped and sets ICOV. History still updates.
- Undefined: no divider; F = 0 always; latency as stated in Behaviour.

Test Plan:
- Rising edges: TW=16, DEPTH=5, ICTMR=01, timer +1/cycle, rising edge every 20 cycles -> no word after edges 1-4; after edge 5 ICBNE=1 and ICBUF=0xC00000C8 at E+2. With IC_FREQ_DIV_EN, ICBUF=0xC9C400C8 at E+34.
- Timer wrap: same stimulus with the timer starting at 0xFFC0 so captures straddle the wrap -> every result after edge 5 is 0xC00000C8.
- Both edges: ICTMR=11, high 30 / low 70 cycles -> stable with P=100 ticks, ICBUF=0xC00003E8.
- Jitter: rising-edge spacing 20,20,21,20 -> ICBUF=0x80000000.
- Overflow: OUT_DEPTH=4, 6 results with no reads -> ICOV=1 and 4 words held. One `rd_i` -> ICOV=0 and 3 words left. Push and pop in the same cycle while full -> ICOV stays 0.
- Reset and mode change: assert `rst` mid-stream (and mid-division with the macro) -> next cycle ICBNE=0, ICOV=0, ICBUF=0. Change ICTMR 01->10 mid-stream -> no result until 5 falling-edge captures; queued words are retained.
